// File: rtl/i2c_trigger_sniffer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | i2c_trigger_sniffer_pkg : shared FSM encoding and word helpers      |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
package i2c_trigger_sniffer_pkg;

  localparam int WORD_W = 9;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_DELAY = 3'd2,
    ST_FIRE  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Masked compare: a 0 mask bit makes that bit a don't-care.
  function automatic logic word_hit(input logic [WORD_W-1:0] w,
                                    input logic [WORD_W-1:0] p,
                                    input logic [WORD_W-1:0] m);
    return ((w ^ p) & m) == '0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_trigger_sniffer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | i2c_trigger_sniffer_if : sniffed buses, pattern config and trigger  |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
interface i2c_trigger_sniffer_if
  import i2c_trigger_sniffer_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int PAT_LEN = 4,
  parameter int DLY_W   = 32,
  parameter int PW_W    = 16
);
  localparam int CSW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int IDXW = $clog2(PAT_LEN + 1);

  logic [NCH-1:0]            scl;
  logic [NCH-1:0]            sda;
  logic [NCH-1:0]            word_valid;
  logic [NCH*WORD_W-1:0]     word;
  logic                      arm;
  logic [CSW-1:0]            chan_sel;
  logic [PAT_LEN*WORD_W-1:0] pat_word;
  logic [PAT_LEN*WORD_W-1:0] pat_mask;
  logic [DLY_W-1:0]          delay;
  logic [PW_W-1:0]           pulse_w;
  logic                      trig;
  logic [2:0]                state;
  logic [IDXW-1:0]           match_idx;

  modport master (
    output scl, sda, arm, chan_sel, pat_word, pat_mask, delay, pulse_w,
    input  word_valid, word, trig, state, match_idx
  );

  modport slave (
    input  scl, sda, arm, chan_sel, pat_word, pat_mask, delay, pulse_w,
    output word_valid, word, trig, state, match_idx
  );

endinterface
`default_nettype wire

// File: rtl/i2c_chan_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | i2c_chan_decoder : one-bus synchroniser, START/STOP and 9-bit shift |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module i2c_chan_decoder
  import i2c_trigger_sniffer_pkg::*;
#(
  parameter int SYNC = 2
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              i_scl,
  input  wire logic              i_sda,
  output logic                   o_word_valid,
  output logic [WORD_W-1:0]      o_word,
  output logic                   o_start_stop
);

  logic [SYNC-1:0]   r_scl_sync;
  logic [SYNC-1:0]   r_sda_sync;
  logic              r_scl_prev;
  logic              r_sda_prev;
  logic [WORD_W-2:0] r_shift;
  logic [3:0]        r_cnt;
  logic              r_vld;
  logic [WORD_W-1:0] r_word;
  logic              r_ss;

  logic w_scl;
  logic w_sda;
  logic w_scl_rise;
  logic w_scl_chg;
  logic w_start;
  logic w_stop;

  assign w_scl      = r_scl_sync[SYNC-1];
  assign w_sda      = r_sda_sync[SYNC-1];
  assign w_scl_rise = w_scl & ~r_scl_prev;
  assign w_scl_chg  = w_scl ^ r_scl_prev;
  // An SCL edge in the same sample as an SDA edge suppresses START/STOP.
  assign w_start    = ~w_scl_chg & w_scl &  r_sda_prev & ~w_sda;
  assign w_stop     = ~w_scl_chg & w_scl & ~r_sda_prev &  w_sda;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_vld      <= 1'b0;
      r_word     <= '0;
      r_ss       <= 1'b0;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[SYNC-2:0], i_sda};
      r_scl_prev <= w_scl;
      r_sda_prev <= w_sda;
      r_vld      <= 1'b0;
      r_ss       <= w_start | w_stop;
      if (w_start || w_stop) begin
        r_cnt <= '0;
      end else if (w_scl_rise) begin
        r_shift <= {r_shift[WORD_W-3:0], w_sda};
        if (r_cnt == 4'd8) begin
          r_word <= {r_shift, w_sda};
          r_vld  <= 1'b1;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + 4'd1;
        end
      end
    end
  end

  assign o_word_valid = r_vld;
  assign o_word       = r_word;
  assign o_start_stop = r_ss;

endmodule
`default_nettype wire

// File: rtl/i2c_trigger_sniffer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | i2c_trigger_sniffer : NCH-bus I2C decode with masked-sequence trigger|
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module i2c_trigger_sniffer
  import i2c_trigger_sniffer_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int PAT_LEN = 4,
  parameter int DLY_W   = 32,
  parameter int PW_W    = 16,
  parameter int SYNC    = 2
) (
  input  wire logic            clk,
  input  wire logic            reset,
  i2c_trigger_sniffer_if.slave bus
);

  localparam int CSW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int IDXW = $clog2(PAT_LEN + 1);

  logic [NCH-1:0]        w_wv;
  logic [NCH*WORD_W-1:0] w_word;
  logic [NCH-1:0]        w_ss;

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    i2c_chan_decoder #(.SYNC(SYNC)) u_dec (
      .clk          (clk),
      .reset        (reset),
      .i_scl        (bus.scl[c]),
      .i_sda        (bus.sda[c]),
      .o_word_valid (w_wv[c]),
      .o_word       (w_word[c*WORD_W +: WORD_W]),
      .o_start_stop (w_ss[c])
    );
  end

  state_e            r_state;
  logic [IDXW-1:0]   r_idx;
  logic [CSW-1:0]    r_chan;
  logic [DLY_W-1:0]  r_dly;
  logic [PW_W-1:0]   r_pw;
  logic [DLY_W-1:0]  r_cnt;
  logic [PW_W-1:0]   r_pcnt;
  logic              r_trig;

  state_e            w_state_nxt;
  logic [IDXW-1:0]   w_idx_nxt;
  logic [CSW-1:0]    w_chan_nxt;
  logic [DLY_W-1:0]  w_dly_nxt;
  logic [PW_W-1:0]   w_pw_nxt;
  logic [DLY_W-1:0]  w_cnt_nxt;
  logic [PW_W-1:0]   w_pcnt_nxt;
  logic              w_sel_vld;
  logic              w_sel_ss;
  logic [WORD_W-1:0] w_sel_word;
  logic [WORD_W-1:0] w_pat_cur;
  logic [WORD_W-1:0] w_msk_cur;
  logic              w_hit_cur;
  logic              w_hit_0;
  logic [PW_W-1:0]   w_pw_m1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_chan  <= '0;
      r_dly   <= '0;
      r_pw    <= '0;
      r_cnt   <= '0;
      r_pcnt  <= '0;
      r_trig  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_chan  <= w_chan_nxt;
      r_dly   <= w_dly_nxt;
      r_pw    <= w_pw_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pcnt  <= w_pcnt_nxt;
      r_trig  <= (w_state_nxt == ST_FIRE);
    end
  end

  always_comb begin
    w_sel_vld  = 1'b0;
    w_sel_ss   = 1'b0;
    w_sel_word = '0;
    for (int c = 0; c < NCH; c++) begin
      if (r_chan == CSW'(c)) begin
        w_sel_vld  = w_wv[c];
        w_sel_ss   = w_ss[c];
        w_sel_word = w_word[c*WORD_W +: WORD_W];
      end
    end
    w_pat_cur = '0;
    w_msk_cur = '0;
    for (int k = 0; k < PAT_LEN; k++) begin
      if (r_idx == IDXW'(k)) begin
        w_pat_cur = bus.pat_word[k*WORD_W +: WORD_W];
        w_msk_cur = bus.pat_mask[k*WORD_W +: WORD_W];
      end
    end
  end

  assign w_hit_cur = word_hit(w_sel_word, w_pat_cur, w_msk_cur);
  assign w_hit_0   = word_hit(w_sel_word, bus.pat_word[WORD_W-1:0], bus.pat_mask[WORD_W-1:0]);
  // Pulse-width reload value; a programmed width of 0 behaves as 1.
  assign w_pw_m1   = (r_pw == '0) ? '0 : r_pw - PW_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_chan_nxt  = r_chan;
    w_dly_nxt   = r_dly;
    w_pw_nxt    = r_pw;
    w_cnt_nxt   = r_cnt;
    w_pcnt_nxt  = r_pcnt;
    case (r_state)
      ST_IDLE: begin
        if (bus.arm) begin
          w_state_nxt = ST_ARMED;
          w_chan_nxt  = bus.chan_sel;
          w_dly_nxt   = bus.delay;
          w_pw_nxt    = bus.pulse_w;
          w_idx_nxt   = '0;
        end
      end
      ST_ARMED: begin
        if (!bus.arm) begin
          w_state_nxt = ST_IDLE;
        end else if (w_sel_ss) begin
          w_idx_nxt = '0;
        end else if (w_sel_vld) begin
          if (w_hit_cur) begin
            w_idx_nxt = r_idx + IDXW'(1);
            if (r_idx == IDXW'(PAT_LEN - 1)) begin
              if (r_dly == '0) begin
                w_state_nxt = ST_FIRE;
                w_pcnt_nxt  = w_pw_m1;
              end else begin
                w_state_nxt = ST_DELAY;
                w_cnt_nxt   = r_dly - DLY_W'(1);
              end
            end
          end else begin
            w_idx_nxt = w_hit_0 ? IDXW'(1) : '0;
          end
        end
      end
      ST_DELAY: begin
        if (!bus.arm) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == '0) begin
          w_state_nxt = ST_FIRE;
          w_pcnt_nxt  = w_pw_m1;
        end else begin
          w_cnt_nxt = r_cnt - DLY_W'(1);
        end
      end
      ST_FIRE: begin
        if (!bus.arm) begin
          w_state_nxt = ST_IDLE;
        end else if (r_pcnt == '0) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_pcnt_nxt = r_pcnt - PW_W'(1);
        end
      end
      ST_DONE: begin
        if (!bus.arm) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.word_valid = w_wv;
  assign bus.word       = w_word;
  assign bus.trig       = r_trig;
  assign bus.state      = r_state;
  assign bus.match_idx  = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_i2c_trigger_sniffer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_i2c_trigger_sniffer : randomized bus traffic vs sequence model   |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_i2c_trigger_sniffer;
  import i2c_trigger_sniffer_pkg::*;

  localparam int NCH = 2, PAT_LEN = 3, DLY_W = 16, PW_W = 8, SYNC = 2, H = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  i2c_trigger_sniffer_if #(.NCH(NCH), .PAT_LEN(PAT_LEN), .DLY_W(DLY_W), .PW_W(PW_W)) bus ();
  i2c_trigger_sniffer #(.NCH(NCH), .PAT_LEN(PAT_LEN), .DLY_W(DLY_W), .PW_W(PW_W), .SYNC(SYNC)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  int ntests = 0;
  int nfail  = 0;

  typedef struct packed { logic [31:0] ch; logic [8:0] w; logic [31:0] cyc; } wv_t;
  wv_t wv_q[$];
  int  rise_q[$];
  int  width_q[$];
  int  cyc = 0;
  int  trig_run = 0;

  always @(posedge clk) begin
    #1;
    cyc++;
    for (int c = 0; c < NCH; c++)
      if (bus.word_valid[c]) wv_q.push_back('{32'(c), bus.word[c*9 +: 9], 32'(cyc)});
    if (bus.trig === 1'b1) begin
      if (trig_run == 0) rise_q.push_back(cyc);
      trig_run++;
    end else if (trig_run > 0) begin
      width_q.push_back(trig_run);
      trig_run = 0;
    end
  end

  logic [8:0] mp [PAT_LEN];
  logic [8:0] mm [PAT_LEN];
  int         tk_kind[$];
  logic [8:0] tk_w[$];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic i2c_start(input int ch);
    if (bus.scl[ch] == 1'b0) begin
      bus.sda[ch] = 1'b1; tick(H); bus.scl[ch] = 1'b1; tick(H);
    end
    bus.sda[ch] = 1'b0; tick(H); bus.scl[ch] = 1'b0; tick(H);
  endtask

  task automatic i2c_stop(input int ch);
    bus.sda[ch] = 1'b0; tick(H); bus.scl[ch] = 1'b1; tick(H); bus.sda[ch] = 1'b1; tick(H);
  endtask

  task automatic i2c_bits(input int ch, input logic [8:0] w, input int n);
    for (int b = 8; b > 8 - n; b--) begin
      bus.sda[ch] = w[b]; tick(H); bus.scl[ch] = 1'b1; tick(H); bus.scl[ch] = 1'b0; tick(H);
    end
  endtask

  task automatic apply_pat();
    for (int j = 0; j < PAT_LEN; j++) begin
      bus.pat_word[j*9 +: 9] = mp[j];
      bus.pat_mask[j*9 +: 9] = mm[j];
    end
  endtask

  task automatic arm_with(input int sel, input int dly, input int pw);
    bus.arm = 1'b0; tick(2);
    bus.chan_sel = 1'(sel); bus.delay = DLY_W'(dly); bus.pulse_w = PW_W'(pw);
    bus.arm = 1'b1; tick(2);
  endtask

  task automatic send_tokens(input int ch);
    foreach (tk_kind[i]) begin
      if (tk_kind[i] == 1)      i2c_start(ch);
      else if (tk_kind[i] == 2) i2c_stop(ch);
      else                      i2c_bits(ch, tk_w[i], 9);
    end
  endtask

  // Sequence rule: a hit advances; a miss restarts and re-tests pattern[0];
  // START/STOP restarts. Returns the ordinal of the completing word or -1.
  function automatic int model_match();
    int idx = 0;
    int wc  = 0;
    foreach (tk_kind[i]) begin
      if (tk_kind[i] != 0) idx = 0;
      else begin
        if (((tk_w[i] ^ mp[idx]) & mm[idx]) == 9'd0) idx++;
        else idx = (((tk_w[i] ^ mp[0]) & mm[0]) == 9'd0) ? 1 : 0;
        if (idx == PAT_LEN) return wc;
        wc++;
      end
    end
    return -1;
  endfunction

  task automatic run_scenario(input string nm, input int ch, input int sel, input int dly, input int pw);
    int wb, rb, wdb, k, other, pwe;
    logic [8:0] exp_w[$];
    logic [8:0] got_w[$];
    int got_c[$];
    arm_with(sel, dly, pw);
    wb = wv_q.size(); rb = rise_q.size(); wdb = width_q.size();
    send_tokens(ch);
    tick(dly + pw + 40);
    foreach (tk_kind[i]) if (tk_kind[i] == 0) exp_w.push_back(tk_w[i]);
    other = 0;
    for (int i = wb; i < wv_q.size(); i++) begin
      if (int'(wv_q[i].ch) == ch) begin got_w.push_back(wv_q[i].w); got_c.push_back(int'(wv_q[i].cyc)); end
      else other++;
    end
    ntests++;
    if (got_w.size() != exp_w.size() || other != 0) begin
      nfail++;
      $display("FAIL %s word_count: got %0d (other ch %0d) expected %0d", nm, got_w.size(), other, exp_w.size());
    end
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
      ntests++;
      if (got_w[i] !== exp_w[i]) begin
        nfail++;
        $display("FAIL %s word[%0d]: got %03h expected %03h", nm, i, got_w[i], exp_w[i]);
      end
    end
    k = (ch == sel) ? model_match() : -1;
    pwe = (pw == 0) ? 1 : pw;
    ntests++;
    if (rise_q.size() - rb != ((k >= 0) ? 1 : 0)) begin
      nfail++;
      $display("FAIL %s trig_count: got %0d expected %0d", nm, rise_q.size() - rb, (k >= 0) ? 1 : 0);
    end else if (k >= 0) begin
      ntests++;
      if (k >= got_c.size() || rise_q[rb] != got_c[k] + dly + 1) begin
        nfail++;
        $display("FAIL %s trig_time: got %0d expected word_valid %0d + %0d", nm, rise_q[rb],
                 (k < got_c.size()) ? got_c[k] : -1, dly + 1);
      end
      ntests++;
      if (width_q.size() <= wdb || width_q[wdb] != pwe) begin
        nfail++;
        $display("FAIL %s trig_width: got %0d expected %0d", nm,
                 (width_q.size() > wdb) ? width_q[wdb] : -1, pwe);
      end
    end
  endtask

  task automatic set_pat3(input logic [8:0] p0, p1, p2, input logic [8:0] m);
    mp[0] = p0; mp[1] = p1; mp[2] = p2;
    for (int j = 0; j < PAT_LEN; j++) mm[j] = m;
    apply_pat();
  endtask

  task automatic check(input string nm, input int got, input int exp);
    ntests++;
    if (got != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic test_reset();
    tick(3);
    check("reset_trig", int'(bus.trig), 0);
    check("reset_word_valid", int'(bus.word_valid), 0);
    check("reset_word", int'(bus.word), 0);
    check("reset_state", int'(bus.state), 0);
    check("reset_match_idx", int'(bus.match_idx), 0);
    reset = 1'b0;
    tick(10);
    check("idle_no_words", wv_q.size(), 0);
  endtask

  task automatic test_partial_byte();
    int wb;
    logic [8:0] w;
    wb = wv_q.size();
    i2c_start(0); i2c_bits(0, 9'h1FF, 5); i2c_stop(0); tick(10);
    check("partial_discarded", wv_q.size() - wb, 0);
    w = 9'($urandom);
    i2c_start(0); i2c_bits(0, w, 9); i2c_stop(0); tick(10);
    check("after_partial_count", wv_q.size() - wb, 1);
    if (wv_q.size() > wb) check("after_partial_word", int'(wv_q[wb].w), int'(w));
  endtask

  task automatic test_sel_match();
    set_pat3({8'h4A, 1'b0}, {8'h10, 1'b0}, {8'hC3, 1'b0}, 9'h1FF);
    tk_kind = {1, 0, 0, 0, 2};
    tk_w    = {9'h0, mp[0], mp[1], mp[2], 9'h0};
    run_scenario("sel_ch1", 1, 1, 5, 3);
    run_scenario("unsel_ch0", 0, 1, 5, 3);
  endtask

  task automatic test_overlap();
    set_pat3({8'hAA, 1'b0}, {8'hAA, 1'b0}, {8'h55, 1'b0}, 9'h1FF);
    tk_kind = {1, 0, 0, 0, 0, 2};
    tk_w    = {9'h0, mp[0], mp[0], mp[0], mp[2], 9'h0};
    run_scenario("overlap", 1, 1, 4, 2);
  endtask

  task automatic test_restart();
    int rb;
    set_pat3({8'h21, 1'b0}, {8'h42, 1'b0}, {8'h84, 1'b0}, 9'h1FF);
    arm_with(1, 3, 2);
    rb = rise_q.size();
    i2c_start(1); i2c_bits(1, mp[0], 9); tick(6);
    check("restart_idx_after_p0", int'(bus.match_idx), 1);
    i2c_start(1); tick(2);
    check("restart_idx_cleared", int'(bus.match_idx), 0);
    i2c_bits(1, mp[1], 9); i2c_bits(1, mp[2], 9); i2c_stop(1); tick(30);
    check("restart_no_trig", rise_q.size() - rb, 0);
    tk_kind = {1, 0, 1, 0, 0, 2, 1, 0, 0, 0, 2};
    tk_w    = {9'h0, mp[0], 9'h0, mp[1], mp[2], 9'h0, 9'h0, mp[0], mp[1], mp[2], 9'h0};
    run_scenario("restart_full", 1, 1, 3, 2);
  endtask

  task automatic test_mask();
    set_pat3({8'h35, 1'b0}, {8'h35, 1'b0}, {8'h35, 1'b0}, {8'hF0, 1'b0});
    tk_kind = {1, 0, 0, 0, 2};
    tk_w    = {9'h0, {8'h3C, 1'b1}, {8'h3C, 1'b1}, {8'h3C, 1'b1}, 9'h0};
    run_scenario("mask_dly0_pw0", 1, 1, 0, 0);
  endtask

  task automatic test_abort_oneshot();
    int rb;
    set_pat3(9'h0F0, 9'h0F2, 9'h0F4, 9'h1FF);
    arm_with(1, 100, 4);
    rb = rise_q.size();
    i2c_start(1); i2c_bits(1, mp[0], 9); i2c_bits(1, mp[1], 9); i2c_bits(1, mp[2], 9);
    tick(10);
    check("abort_in_delay", int'(bus.state), int'(ST_DELAY));
    bus.arm = 1'b0; tick(1);
    check("abort_state_idle", int'(bus.state), int'(ST_IDLE));
    i2c_stop(1); tick(150);
    check("abort_no_trig", rise_q.size() - rb, 0);
    arm_with(1, 3, 2);
    i2c_start(1); i2c_bits(1, mp[0], 9); i2c_bits(1, mp[1], 9); i2c_bits(1, mp[2], 9); i2c_stop(1);
    tick(20);
    check("rearm_one_trig", rise_q.size() - rb, 1);
    check("done_held", int'(bus.state), int'(ST_DONE));
    i2c_start(1); i2c_bits(1, mp[0], 9); i2c_bits(1, mp[1], 9); i2c_bits(1, mp[2], 9); i2c_stop(1);
    tick(20);
    check("one_shot_only", rise_q.size() - rb, 1);
    check("done_still_held", int'(bus.state), int'(ST_DONE));
    bus.arm = 1'b0; tick(2);
    check("done_to_idle", int'(bus.state), int'(ST_IDLE));
  endtask

  task automatic test_random();
    logic [8:0] alpha [3];
    int ch, sel, nw;
    for (int r = 0; r < 8; r++) begin
      for (int a = 0; a < 3; a++) alpha[a] = 9'($urandom);
      for (int j = 0; j < PAT_LEN; j++) begin
        mp[j] = alpha[$urandom_range(0, 2)];
        mm[j] = ($urandom_range(0, 2) == 0) ? 9'($urandom) : 9'h1FF;
      end
      apply_pat();
      tk_kind.delete(); tk_w.delete();
      tk_kind.push_back(1); tk_w.push_back(9'h0);
      nw = $urandom_range(4, 8);
      for (int i = 0; i < nw; i++) begin
        if ($urandom_range(0, 5) == 0) begin tk_kind.push_back(1); tk_w.push_back(9'h0); end
        tk_kind.push_back(0); tk_w.push_back(alpha[$urandom_range(0, 2)]);
      end
      tk_kind.push_back(2); tk_w.push_back(9'h0);
      ch  = $urandom_range(0, 3) == 0 ? 0 : 1;
      sel = $urandom_range(0, 3) == 0 ? 0 : 1;
      run_scenario($sformatf("random%0d", r), ch, sel, $urandom_range(0, 12), $urandom_range(0, 6));
    end
  endtask

  task automatic test_reset_mid_fire();
    int wb, n;
    set_pat3(9'h033, 9'h066, 9'h0CC, 9'h1FF);
    arm_with(1, 2, 60);
    i2c_start(1); i2c_bits(1, mp[0], 9); i2c_bits(1, mp[1], 9); i2c_bits(1, mp[2], 9);
    n = 0;
    while (bus.trig !== 1'b1 && n < 200) begin tick(1); n++; end
    ntests++;
    if (bus.trig !== 1'b1) begin
      nfail++;
      $display("FAIL fire_wait: got trig %0d expected 1 within 200 cycles", bus.trig);
    end
    tick(3);
    reset = 1'b1;
    #1;
    check("reset_fire_trig", int'(bus.trig), 0);
    check("reset_fire_state", int'(bus.state), 0);
    wb = wv_q.size();
    tick(2);
    reset = 1'b0;
    bus.arm = 1'b0;
    tick(50);
    check("no_word_after_reset", wv_q.size() - wb, 0);
    i2c_stop(1); tick(5);
  endtask

  initial begin
    bus.scl = '1; bus.sda = '1; bus.arm = 1'b0; bus.chan_sel = '0;
    bus.pat_word = '0; bus.pat_mask = '0; bus.delay = '0; bus.pulse_w = '0;
    test_reset();
    test_partial_byte();
    test_sel_match();
    test_overlap();
    test_restart();
    test_mask();
    test_abort_oneshot();
    test_random();
    test_reset_mid_fire();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
`default_nettype wire
